// File: rtl/mod_arith_unit.sv
// Sequential modular arithmetic engine: (a op b) mod p for ADD, SUB, MUL, SQR.
// Multiplication is bit-serial interleaved, MSB-first, one operand bit per cycle.
module mod_arith_unit #(
    parameter int unsigned WIDTH = 256
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_done,
    output logic             o_busy,
    output logic             o_err
);

    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam int unsigned EXT_W = WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ALU,
        S_MUL,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_SQR = 2'b11
    } op_t;

    typedef struct packed {
        op_t              op;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } operands_t;

    state_t           state_q, state_n;
    operands_t        opnd_q, opnd_n;
    logic             start_q;
    logic [WIDTH-1:0] acc_q, acc_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic [WIDTH-1:0] result_n;
    logic             err_n;
    logic             done_n;
    logic             busy_n;

    logic             start_acc;
    logic             invalid;
    logic [EXT_W-1:0] p_ext;
    logic [EXT_W-1:0] add_sum;
    logic [EXT_W-1:0] add_red;
    logic [EXT_W-1:0] sub_diff;
    logic [EXT_W-1:0] sub_fix;
    logic [EXT_W-1:0] mul_dbl;
    logic [EXT_W-1:0] mul_red;
    logic [EXT_W-1:0] mul_add;
    logic [EXT_W-1:0] mul_red2;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] mul_res;

    // Only a rising edge of i_start while idle launches an operation
    assign start_acc = (state_q == S_IDLE) & i_start & ~start_q;

    // Operand validity on the latched copy
    assign invalid = ~opnd_q.p[0]
                   | (opnd_q.p < WIDTH'(3))
                   | (opnd_q.a >= opnd_q.p)
                   | ((opnd_q.op != OP_SQR) & (opnd_q.b >= opnd_q.p));

    // Single-cycle ADD/SUB with one conditional correction
    always_comb begin
        p_ext    = {1'b0, opnd_q.p};
        add_sum  = {1'b0, opnd_q.a} + {1'b0, opnd_q.b};
        add_red  = (add_sum >= p_ext) ? (add_sum - p_ext) : add_sum;
        sub_diff = {1'b0, opnd_q.a} - {1'b0, opnd_q.b};
        sub_fix  = (opnd_q.a < opnd_q.b) ? (sub_diff + p_ext) : sub_diff;
        alu_res  = (opnd_q.op == OP_SUB) ? WIDTH'(sub_fix) : WIDTH'(add_red);
    end

    // One interleaved step: acc = 2*acc mod p, then + a mod p when b[idx] is set
    always_comb begin
        mul_dbl  = {acc_q, 1'b0};
        mul_red  = (mul_dbl >= p_ext) ? (mul_dbl - p_ext) : mul_dbl;
        mul_add  = opnd_q.b[idx_q] ? (mul_red + {1'b0, opnd_q.a}) : mul_red;
        mul_red2 = (mul_add >= p_ext) ? (mul_add - p_ext) : mul_add;
        mul_res  = WIDTH'(mul_red2);
    end

    // Next-state and output logic
    always_comb begin
        state_n  = state_q;
        opnd_n   = opnd_q;
        acc_n    = acc_q;
        idx_n    = idx_q;
        result_n = o_result;
        err_n    = o_err;

        case (state_q)
            S_IDLE: begin
                if (start_acc) begin
                    opnd_n.op = op_t'(i_op);
                    opnd_n.p  = p;
                    opnd_n.a  = a;
                    opnd_n.b  = (op_t'(i_op) == OP_SQR) ? a : b;
                    state_n   = S_CHECK;
                end
            end
            S_CHECK: begin
                if (invalid) begin
                    result_n = '0;
                    err_n    = 1'b1;
                    state_n  = S_DONE;
                end else if ((opnd_q.op == OP_ADD) || (opnd_q.op == OP_SUB)) begin
                    state_n = S_ALU;
                end else begin
                    acc_n   = '0;
                    idx_n   = IDX_W'(WIDTH - 1);
                    state_n = S_MUL;
                end
            end
            S_ALU: begin
                result_n = alu_res;
                err_n    = 1'b0;
                state_n  = S_DONE;
            end
            S_MUL: begin
                acc_n = mul_res;
                if (idx_q == '0) begin
                    result_n = mul_res;
                    err_n    = 1'b0;
                    state_n  = S_DONE;
                end else begin
                    idx_n = idx_q - IDX_W'(1);
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        done_n = (state_n == S_DONE);
        busy_n = (state_n != S_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            start_q  <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            o_result <= '0;
            o_err    <= 1'b0;
            o_done   <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            state_q  <= state_n;
            start_q  <= i_start;
            opnd_q   <= opnd_n;
            acc_q    <= acc_n;
            idx_q    <= idx_n;
            o_result <= result_n;
            o_err    <= err_n;
            o_done   <= done_n;
            o_busy   <= busy_n;
        end
    end

endmodule
